// File: rtl/logic_unit_pipe_pkg.sv
// Shared operation codes for the pipelined bitwise logic unit.
package logic_unit_pipe_pkg;

    typedef enum logic [2:0] {
        LOP_AND   = 3'b000,
        LOP_OR    = 3'b001,
        LOP_NOR   = 3'b010,
        LOP_NOTA  = 3'b011,
        LOP_XOR   = 3'b100,
        LOP_NAND  = 3'b101,
        LOP_XNOR  = 3'b110,
        LOP_PASSB = 3'b111
    } lop_e;

    localparam int unsigned NUM_OPS = 8;

endpackage

// File: rtl/logic_op_n.sv
// Combinational WIDTH-bit logic array: every bit computes all eight ops with
// gate primitives and the op code picks one.
module logic_op_n
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  lop_e             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire [NUM_OPS-1:0] r;

        and  u_and  (r[LOP_AND],  a[i], b[i]);
        or   u_or   (r[LOP_OR],   a[i], b[i]);
        nor  u_nor  (r[LOP_NOR],  a[i], b[i]);
        not  u_nota (r[LOP_NOTA], a[i]);
        xor  u_xor  (r[LOP_XOR],  a[i], b[i]);
        nand u_nand (r[LOP_NAND], a[i], b[i]);
        xnor u_xnor (r[LOP_XNOR], a[i], b[i]);
        assign r[LOP_PASSB] = b[i];

        assign y[i] = r[op];
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit: S1 holds operands, S2 holds the result and
// zero flag; both stages advance independently under backpressure.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and in_ready depends on
    // out_ready combinationally so a full pipe can accept while draining.

    logic             s1_valid;
    lop_e             s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_zero;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] f_y;

    assign s2_load  = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;

    logic_op_n #(.WIDTH(WIDTH)) u_op (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .y  (f_y)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_op    <= LOP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_op    <= lop_e'(in_op);
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Result payload is kept when draining so out_y holds its last value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_zero  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_y     <= f_y;
            s2_zero  <= ~|f_y;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
    assign out_y     = s2_y;
    assign out_zero  = s2_zero;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: 32-bit and 8-bit instances share one stimulus
// bus; a queue-based occupancy model predicts handshakes and results.
module tb_logic_unit_pipe;
    import logic_unit_pipe_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        in_valid  = 1'b0;
    logic [2:0]  in_op     = 3'b000;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic        out_ready = 1'b0;
    logic        sel       = 1'b0;   // 0: 32-bit instance, 1: 8-bit instance

    logic        r32, v32, z32, r8, v8, z8;
    logic [31:0] y32;
    logic [7:0]  y8;
    logic        iv32, iv8;

    assign iv32 = in_valid & ~sel;
    assign iv8  = in_valid & sel;

    logic_unit_pipe #(.WIDTH(32)) dut32 (
        .CLK(CLK), .RST(RST), .in_valid(iv32), .in_ready(r32), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(v32), .out_ready(out_ready),
        .out_y(y32), .out_zero(z32)
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .in_valid(iv8), .in_ready(r8), .in_op(in_op),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(v8), .out_ready(out_ready),
        .out_y(y8), .out_zero(z8)
    );

    logic        m_in_ready, m_out_valid, m_out_zero;
    logic [31:0] m_out_y;
    assign m_in_ready  = sel ? r8 : r32;
    assign m_out_valid = sel ? v8 : v32;
    assign m_out_zero  = sel ? z8 : z32;
    assign m_out_y     = sel ? {24'b0, y8} : y32;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lop(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
        logic [31:0] r;
        logic [31:0] mask;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = ~(a | b);
            3'd3:    r = ~a;
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a & b);
            3'd6:    r = ~(a ^ b);
            default: r = b;
        endcase
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return r & mask;
    endfunction

    logic [32:0] exp_q[$];      // {zero, y} of accepted ops, oldest first
    logic [32:0] got_q[$];      // {zero, y} observed leaving the DUT
    int          got_cyc[$];
    int          cnt      = 0;  // ops inside the pipe after the coming edge
    bit          last_acc = 0;  // previous edge accepted an op
    bit          live     = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_y;
    int          cyc      = 0;
    int          acc_cnt  = 0;

    // One compare process: check at negedge, then advance the model through
    // the coming rising edge.
    always @(negedge CLK) begin
        bit          mv, pop, acc;
        logic [31:0] y;
        cyc++;
        mv = (cnt >= 2) || (cnt == 1 && !last_acc);
        if (live && !RST) begin
            chk("in_ready", {32'b0, m_in_ready}, {32'b0, (cnt < 2) || out_ready});
            chk("out_valid", {32'b0, m_out_valid}, {32'b0, mv});
            if (m_out_valid && exp_q.size() > 0)
                chk("out_data", {m_out_zero, m_out_y}, exp_q[0]);
            if (prev_stall)
                chk("stall_hold", {1'b0, m_out_y}, {1'b0, prev_y});
        end
        prev_stall = live && !RST && m_out_valid && !out_ready;
        prev_y     = m_out_y;
        if (RST) begin
            exp_q.delete();
            cnt      = 0;
            last_acc = 0;
            live     = 1;
            prev_stall = 0;
        end else if (live) begin
            pop = mv && out_ready;
            acc = in_valid && ((cnt < 2) || out_ready);
            if (m_out_valid && out_ready) begin
                got_q.push_back({m_out_zero, m_out_y});
                got_cyc.push_back(cyc);
            end
            if (pop && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                cnt--;
            end
            if (acc) begin
                y = lop(in_op, in_a, in_b, sel ? 8 : 32);
                exp_q.push_back({(y == 32'd0), y});
                cnt++;
                acc_cnt++;
            end
            last_acc = acc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input lop_e op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok       = 0;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (m_in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 33'd0, 33'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic rand_run(input int target);
        int start;
        start = acc_cnt;
        for (int i = 0; i < 8000 && (acc_cnt - start) < target; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 3'($urandom_range(0, 7));
            in_a      = $urandom;
            in_b      = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) in_a = '0;
            tick(1);
        end
        chk("rand_done", {32'b0, (acc_cnt - start) >= target}, 33'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(5);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", {32'b0, m_out_valid}, 33'd0);
        chk("rst_out_zero",  {32'b0, m_out_zero},  33'd0);
        chk("rst_out_y",     {1'b0, m_out_y},      33'd0);
        chk("rst_in_ready",  {32'b0, m_in_ready},  33'd1);
        tick(1);
        out_ready = 1'b1;

        // single AND, latency pin
        send(LOP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        @(negedge CLK);
        chk("lat_not_yet", {32'b0, m_out_valid}, 33'd0);
        @(negedge CLK);
        chk("lat_valid", {32'b0, m_out_valid}, 33'd1);
        chk("and_y", {m_out_zero, m_out_y}, {1'b0, 32'h00F0_000F});
        tick(2);

        // back-to-back stream
        clear_log();
        send(LOP_OR,   32'hAAAA_5555, 32'hFFFF_0000);
        send(LOP_NOR,  32'hAAAA_5555, 32'hFFFF_0000);
        send(LOP_XOR,  32'hAAAA_5555, 32'hFFFF_0000);
        send(LOP_XNOR, 32'hAAAA_5555, 32'hFFFF_0000);
        tick(4);
        chk("b2b_count", 33'(got_q.size()), 33'd4);
        if (got_q.size() == 4) begin
            chk("b2b_or",   got_q[0], {1'b0, 32'hFFFF_5555});
            chk("b2b_nor",  got_q[1], {1'b0, 32'h0000_AAAA});
            chk("b2b_xor",  got_q[2], {1'b0, 32'h5555_5555});
            chk("b2b_xnor", got_q[3], {1'b0, 32'hAAAA_AAAA});
            for (int i = 0; i < 3; i++)
                chk("b2b_gap", 33'(got_cyc[i+1] - got_cyc[i]), 33'd1);
        end

        // NOT A and PASS B
        clear_log();
        send(LOP_NOTA,  32'hFFFF_FFFF, 32'h1234_5678);
        send(LOP_PASSB, 32'hFFFF_FFFF, 32'h1234_5678);
        tick(4);
        chk("nota_pb_count", 33'(got_q.size()), 33'd2);
        if (got_q.size() == 2) begin
            chk("nota_zero", got_q[0], {1'b1, 32'h0});
            chk("passb",     got_q[1], {1'b0, 32'h1234_5678});
        end

        // stall: two accepted, third held, then simultaneous drain/accept
        clear_log();
        out_ready = 1'b0;
        in_a      = 32'hFFFF_0000;
        in_b      = 32'h0F0F_0F0F;
        in_op     = LOP_AND;
        in_valid  = 1'b1;
        @(negedge CLK);
        chk("stall_rdy0", {32'b0, m_in_ready}, 33'd1);
        tick(1);
        in_op = LOP_OR;
        tick(1);
        in_op = LOP_XOR;
        repeat (3) begin
            @(negedge CLK);
            chk("stall_full", {32'b0, m_in_ready}, 33'd0);
        end
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        @(negedge CLK);
        chk("stall_release", {32'b0, m_in_ready}, 33'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        tick(4);
        chk("stall_count", 33'(got_q.size()), 33'd3);
        if (got_q.size() == 3) begin
            chk("stall_and", got_q[0], {1'b0, 32'h0F0F_0000});
            chk("stall_or",  got_q[1], {1'b0, 32'hFFFF_0F0F});
            chk("stall_xor", got_q[2], {1'b0, 32'hF0F0_0F0F});
            for (int i = 0; i < 2; i++)
                chk("stall_gap", 33'(got_cyc[i+1] - got_cyc[i]), 33'd1);
        end

        // reset with both stages full
        out_ready = 1'b0;
        send(LOP_XOR, 32'h1111_1111, 32'h2222_2222);
        send(LOP_OR,  32'h4444_4444, 32'h8888_8888);
        clear_log();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_full_valid", {32'b0, m_out_valid}, 33'd0);
        chk("rst_full_ready", {32'b0, m_in_ready},  33'd1);
        tick(1);
        out_ready = 1'b1;
        tick(4);
        chk("no_stale", 33'(got_q.size()), 33'd0);

        // 8-bit instance
        sel = 1'b1;
        clear_log();
        send(LOP_NAND, 32'h0000_000F, 32'h0000_00FF);
        tick(3);
        chk("nand8_count", 33'(got_q.size()), 33'd1);
        if (got_q.size() == 1) chk("nand8", got_q[0], {1'b0, 32'h0000_00F0});
        rand_run(1000);

        // 32-bit random run
        sel = 1'b0;
        rand_run(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
